// File: rtl/pipe_link_rx.sv
// Receive end of a flop-pipelined link: a circular buffer that absorbs the words
// still in flight after stop is raised, with a sticky flag for any dropped word.
module pipe_link_rx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1,
    parameter int unsigned BUF   = 2*DEPTH+3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             stop,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_rdy,
    output logic             ovf
);

    localparam int unsigned PW  = (BUF > 1) ? $clog2(BUF) : 1;
    localparam int unsigned CW  = $clog2(BUF+1);
    // stop is raised early enough that every word already in flight still fits
    localparam int unsigned THR = BUF - (2*DEPTH+1);

    generate
        if (BUF < 2*DEPTH+2) begin : g_bad_buf
            $error("pipe_link_rx: BUF must be at least 2*DEPTH+2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [BUF];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             vld_q;
    logic             push;
    logic             pop;
    logic             full;

    assign full     = (cnt == CW'(BUF));
    assign pop      = vld_q & out_rdy;
    assign push     = in_vld & (~full | pop);
    assign out_vld  = vld_q;
    assign out_data = mem[rp];

    // Post-update occupancy; push and pop together leave it unchanged.
    always_comb begin
        cnt_next = cnt;
        if (push && !pop) begin
            cnt_next = cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_next = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wp] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            vld_q <= 1'b0;
            stop  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                wp <= (wp == PW'(BUF-1)) ? '0 : wp + PW'(1);
            end
            if (pop) begin
                rp <= (rp == PW'(BUF-1)) ? '0 : rp + PW'(1);
            end
            cnt   <= cnt_next;
            vld_q <= (cnt_next != '0);
            stop  <= (cnt_next >= CW'(THR));
            if (in_vld && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_link_rx.sv
// Randomized bench for pipe_link_rx: a queue-based model of the receive buffer
// feeds a scoreboard that a negedge monitor checks against the DUT outputs.
module tb_pipe_link_rx;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 1;
    localparam int unsigned BUF   = 5;
    localparam int unsigned THR   = BUF - (2*DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_vld = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             stop;
    logic             out_vld;
    logic [WIDTH-1:0] out_data;
    logic             out_rdy = 1'b0;
    logic             ovf;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    bit exp_stop = 1'b0;
    bit exp_ovf  = 1'b0;

    // sender-side link model: one flop on the stop return, one on the data path
    logic             stop_d = 1'b0;
    bit               snd_q = 1'b0;
    logic [WIDTH-1:0] snd_data = '0;
    logic [WIDTH-1:0] next_word = '0;

    pipe_link_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BUF(BUF)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .stop     (stop),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) stop_d <= stop;

    // Reference model: the buffer is a queue; a word is kept only if room remains
    // after this edge's pop, which the monitor has already removed from the queue.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_stop = 1'b0;
            exp_ovf  = 1'b0;
        end else begin
            if (in_vld) begin
                if (exp_q.size() < BUF) exp_q.push_back(in_data);
                else exp_ovf = 1'b1;
            end
            exp_stop = (exp_q.size() >= THR);
        end
    end

    // Monitor: compares every output each cycle; consumes the head on a handshake.
    always @(negedge clk) begin
        checks++;
        if (stop !== exp_stop) begin
            failures++;
            $display("FAIL stop: got %b expected %b at %0t", stop, exp_stop, $time);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            failures++;
            $display("FAIL ovf: got %b expected %b at %0t", ovf, exp_ovf, $time);
        end
        checks++;
        if (exp_q.size() == 0) begin
            if (out_vld !== 1'b0) begin
                failures++;
                $display("FAIL out_vld_empty: got %b expected 0 at %0t", out_vld, $time);
            end
        end else begin
            if (out_vld !== 1'b1) begin
                failures++;
                $display("FAIL out_vld: got %b expected 1 at %0t", out_vld, $time);
            end
            checks++;
            if (out_data !== exp_q[0]) begin
                failures++;
                $display("FAIL out_data: got %h expected %h at %0t", out_data, exp_q[0], $time);
            end
            if (out_rdy) void'(exp_q.pop_front());
        end
    end

    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    // Compliant sender: sends only while the flopped stop it sees is low.
    task automatic sender_run(input int n, input bit rand_rdy);
        for (int i = 0; i < n; i++) begin
            in_vld  = snd_q;
            in_data = snd_data;
            if (!stop_d) begin
                snd_q     = 1'b1;
                snd_data  = next_word;
                next_word = next_word + WIDTH'(1);
            end else begin
                snd_q = 1'b0;
            end
            out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
        end
        snd_q = 1'b0;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        rst = 1'b0;
        idle(2);

        // streaming 0x01..0x10 with the consumer always ready
        for (int i = 1; i <= 16; i++) drive(1'b1, WIDTH'(i), 1'b1);
        idle(4);

        // backpressure through the modelled link, then random drain
        pulse_reset();
        sender_run(15, 1'b0);
        sender_run(200, 1'b1);
        idle(10);

        // full buffer with simultaneous push and pop
        pulse_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, WIDTH'(8'h10 + i), 1'b0);
        drive(1'b1, 8'h55, 1'b1);

        // full buffer, no pop: 0xAA must be dropped and ovf must stick
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        idle(8);

        // random traffic across many pointer wraps
        pulse_reset();
        for (int i = 0; i < 80; i++)
            drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        idle(8);

        // reset mid-operation with a word presented during the reset cycle
        for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(8'h30 + i), 1'b0);
        rst = 1'b1;
        drive(1'b1, 8'hEE, 1'b0);
        rst = 1'b0;
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
